// File: rtl/serial_compare_scheduler.sv
// serial_compare_scheduler: round-robin front end that time-shares one
// MSB-first serial comparator between N_REQ requesters. The winning operand
// pair is latched, the comparator is cleared, both operands are streamed out
// one bit per cycle, and the three-way result is returned tagged with the
// requester index.
//
// state    | meaning
// S_IDLE   | arbitrate, accept one request
// S_CLEAR  | one-cycle comparator clear, load bit counter
// S_SHIFT  | stream WIDTH operand bits MSB first, capture on last bit
// S_RESULT | hold result until the consumer takes it
module serial_compare_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDW-1:0]         res_id,
  output logic                   res_less,
  output logic                   res_eq,
  output logic                   res_greater,
  output logic                   busy,
  output logic                   cmp_clr,
  output logic                   cmp_a,
  output logic                   cmp_b,
  input  logic                   cmp_less,
  input  logic                   cmp_eq,
  input  logic                   cmp_greater
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_RESULT} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             less_q, less_d, eq_q, eq_d, greater_q, greater_d;
  logic             res_valid_q, res_valid_d, busy_q, busy_d;
  logic             cmp_clr_q, cmp_clr_d, cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;

  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Round-robin search from rr_ptr; descending loop so the lowest offset wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is combinational so it tracks req_valid while idle (also in reset).
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  // Next-state and datapath updates; outputs are derived from the next state
  // so every output leaves a flop.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    res_id_d  = res_id_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    less_d    = less_q;
    eq_d      = eq_q;
    greater_d = greater_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          a_sh_d   = sel_a;
          b_sh_d   = sel_b;
          res_id_d = grant_idx;
          rr_ptr_d = IDW'((int'(grant_idx) + 1) % N_REQ);
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q << 1;
        if (cnt_q == '0) begin
          less_d    = cmp_less;
          eq_d      = cmp_eq;
          greater_d = cmp_greater;
          state_d   = S_RESULT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    res_valid_d = (state_d == S_RESULT);
    busy_d      = (state_d != S_IDLE);
    cmp_clr_d   = (state_d == S_CLEAR);
    cmp_a_d     = (state_d == S_SHIFT) && a_sh_d[WIDTH-1];
    cmp_b_d     = (state_d == S_SHIFT) && b_sh_d[WIDTH-1];
  end

  // State and output registers; reset discards any in-flight comparison.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      res_id_q    <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      less_q      <= 1'b0;
      eq_q        <= 1'b0;
      greater_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cmp_clr_q   <= 1'b0;
      cmp_a_q     <= 1'b0;
      cmp_b_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      res_id_q    <= res_id_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      cnt_q       <= cnt_d;
      less_q      <= less_d;
      eq_q        <= eq_d;
      greater_q   <= greater_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      cmp_clr_q   <= cmp_clr_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_less    = less_q;
  assign res_eq      = eq_q;
  assign res_greater = greater_q;
  assign busy        = busy_q;
  assign cmp_clr     = cmp_clr_q;
  assign cmp_a       = cmp_a_q;
  assign cmp_b       = cmp_b_q;

endmodule

// File: tb/tb_serial_compare_scheduler.sv
// Bench for serial_compare_scheduler: behavioural serial comparator, request
// driver with a round-robin reference, and a result scoreboard.
module tb_serial_compare_scheduler;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a, req_b;
  logic                   res_valid, res_ready = 1'b1;
  logic [IDW-1:0]         res_id;
  logic                   res_less, res_eq, res_greater, busy;
  logic                   cmp_clr, cmp_a, cmp_b;
  logic                   cmp_less, cmp_eq, cmp_greater;

  logic [WIDTH-1:0] a_arr[N_REQ];
  logic [WIDTH-1:0] b_arr[N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_pack
    assign req_a[g*WIDTH +: WIDTH] = a_arr[g];
    assign req_b[g*WIDTH +: WIDTH] = b_arr[g];
  end

  serial_compare_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_less(res_less), .res_eq(res_eq), .res_greater(res_greater),
    .busy(busy), .cmp_clr(cmp_clr), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_less(cmp_less), .cmp_eq(cmp_eq), .cmp_greater(cmp_greater)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial comparator: remembers the first differing bit since the last clear.
  logic [1:0] cst;
  always @(posedge clk or negedge rst) begin
    if (!rst) cst <= 2'd0;
    else if (cmp_clr) cst <= 2'd0;
    else if (cst == 2'd0 && cmp_a != cmp_b) cst <= cmp_a ? 2'd2 : 2'd1;
  end
  assign cmp_less    = (cst == 2'd1) || (cst == 2'd0 && !cmp_a && cmp_b);
  assign cmp_greater = (cst == 2'd2) || (cst == 2'd0 && cmp_a && !cmp_b);
  assign cmp_eq      = (cst == 2'd0) && (cmp_a == cmp_b);

  typedef struct {int id; int l; int e; int g; int due;} exp_t;
  exp_t exp_q[$];
  int   grant_log[$];
  int   rise_q[$];
  int   errors = 0, checks = 0;
  int   model_rr = 0, free_cyc = 0, refill = 0, grant_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (model_rr + k) % N_REQ;
      if ((req_valid & (N_REQ'(1) << i)) != '0) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_arr[i] = a;
    b_arr[i] = b;
    req_valid = req_valid | (N_REQ'(1) << i);
  endtask

  // One clock: check arbitration with the inputs as they stand, then advance.
  task automatic tick();
    int idx, pred, granted;
    exp_t e;
    granted = -1;
    #1;
    if (rst) begin
      chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
      chk("ready_when_idle", int'(req_ready != '0),
          int'(exp_q.size() == 0 && cyc >= free_cyc && req_valid != '0));
      if (req_ready != '0) begin
        idx = -1;
        for (int k = 0; k < N_REQ; k++)
          if ((req_ready & (N_REQ'(1) << k)) != '0) idx = k;
        pred = model_grant();
        chk("grant_idx", idx, pred);
        if (idx >= 0) begin
          e.id  = idx;
          e.l   = int'(a_arr[idx] < b_arr[idx]);
          e.e   = int'(a_arr[idx] == b_arr[idx]);
          e.g   = int'(a_arr[idx] > b_arr[idx]);
          e.due = cyc + WIDTH + 2;
          exp_q.push_back(e);
          model_rr = (idx + 1) % N_REQ;
          grant_log.push_back(idx);
          grant_cnt++;
          granted = idx;
        end
      end
    end
    @(posedge clk);
    #2;
    if (granted >= 0) begin
      if (refill > 0) begin
        refill--;
        a_arr[granted] = WIDTH'($urandom);
        b_arr[granted] = WIDTH'($urandom);
      end else begin
        req_valid = req_valid & ~(N_REQ'(1) << granted);
      end
    end
  endtask

  task automatic wait_grant();
    int n0, n;
    n0 = grant_cnt;
    n = 0;
    while (grant_cnt == n0 && n < 100) begin tick(); n++; end
    if (grant_cnt == n0) chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((req_valid != '0 || exp_q.size() != 0 || busy) && n < 3000) begin tick(); n++; end
    if (n >= 3000) chk("idle_timeout", 0, 1);
  endtask

  // Result monitor: pops the scoreboard on every result handshake.
  initial begin
    bit   prev_v;
    int   first;
    exp_t e;
    prev_v = 1'b0;
    first = 0;
    forever begin
      @(posedge clk);
      #4;
      if (!rst) prev_v = 1'b0;
      else if (res_valid) begin
        if (!prev_v) begin first = cyc; rise_q.push_back(cyc); end
        chk("busy_in_result", int'(busy), 1);
        if (res_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("res_id", int'(res_id), e.id);
            chk("res_less", int'(res_less), e.l);
            chk("res_eq", int'(res_eq), e.e);
            chk("res_greater", int'(res_greater), e.g);
            chk("res_latency", first, e.due);
          end
          free_cyc = cyc + 1;
          prev_v = 1'b0;
        end else prev_v = 1'b1;
      end else prev_v = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] sa, sb;
    int id0, l0, e0, g0;
    for (int i = 0; i < N_REQ; i++) begin a_arr[i] = '0; b_arr[i] = '0; end

    // Reset values, and ready following valid while in reset.
    repeat (3) @(posedge clk);
    #2;
    req_valid = 4'b0110;
    #1;
    chk("rst_ready_follows_valid", int'(req_ready), 2);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_bits", int'({res_less, res_eq, res_greater}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmp_clr", int'(cmp_clr), 0);
    chk("rst_cmp_ab", int'({cmp_a, cmp_b}), 0);
    req_valid = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Single greater with serial bit stream check.
    set_req(0, 8'h64, 8'h62);
    wait_grant();
    chk("clear_pulse", int'(cmp_clr), 1);
    sa = 8'h64;
    sb = 8'h62;
    for (int j = 0; j < WIDTH; j++) begin
      tick();
      chk("shift_clr_low", int'(cmp_clr), 0);
      chk("cmp_a_bit", int'(cmp_a), int'(sa[WIDTH-1]));
      chk("cmp_b_bit", int'(cmp_b), int'(sb[WIDTH-1]));
      sa = sa << 1;
      sb = sb << 1;
    end
    tick();
    chk("res_valid_at_T10", int'(res_valid), 1);
    wait_idle();

    // Equal and less.
    set_req(2, 8'hA5, 8'hA5);
    wait_idle();
    set_req(1, 8'h0F, 8'hF0);
    wait_idle();

    // Wrap priority: after serving 3, 0 beats 1.
    set_req(3, 8'h10, 8'h20);
    wait_idle();
    grant_log.delete();
    set_req(1, 8'h33, 8'h33);
    set_req(0, 8'h80, 8'h7F);
    wait_idle();
    chk("wrap_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("wrap_first", grant_log[0], 0);
      chk("wrap_second", grant_log[1], 1);
    end

    // Backpressure in RESULT.
    res_ready = 1'b0;
    set_req(2, 8'hC3, 8'h3C);
    wait_grant();
    set_req(1, 8'h05, 8'h06);
    begin
      int n;
      n = 0;
      while (!res_valid && n < 50) begin tick(); n++; end
      if (!res_valid) chk("bp_result_timeout", 0, 1);
    end
    id0 = int'(res_id); l0 = int'(res_less); e0 = int'(res_eq); g0 = int'(res_greater);
    chk("bp_first_id", id0, 2);
    chk("bp_first_greater", g0, 1);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("bp_valid_held", int'(res_valid), 1);
      chk("bp_id_held", int'(res_id), id0);
      chk("bp_bits_held", int'({res_less, res_eq, res_greater}), (l0 << 2) | (e0 << 1) | g0);
      chk("bp_busy", int'(busy), 1);
      chk("bp_no_ready", int'(req_ready), 0);
    end
    res_ready = 1'b1;
    tick();
    chk("bp_idle_after", int'(busy), 0);
    chk("bp_ready_after", int'(req_ready), 2);
    wait_idle();

    // Reset during SHIFT.
    set_req(0, 8'hFF, 8'hFF);
    wait_grant();
    repeat (4) tick();
    chk("pre_reset_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cmp", int'({cmp_clr, cmp_a, cmp_b}), 0);
    chk("mid_rst_res_id", int'(res_id), 0);
    exp_q.delete();
    model_rr = 0;
    free_cyc = 0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("no_result_after_reset", int'(res_valid), 0);
    set_req(3, 8'h01, 8'h80);
    wait_idle();

    // Contention: all four, requester 0 re-requests once.
    grant_log.delete();
    rise_q.delete();
    for (int i = 0; i < N_REQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom));
    refill = 1;
    wait_idle();
    chk("cont_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      chk("cont_g0", grant_log[0], 0);
      chk("cont_g1", grant_log[1], 1);
      chk("cont_g2", grant_log[2], 2);
      chk("cont_g3", grant_log[3], 3);
      chk("cont_g4", grant_log[4], 0);
    end
    chk("cont_rises", rise_q.size(), 5);
    for (int k = 1; k < rise_q.size(); k++) chk("cont_spacing", rise_q[k] - rise_q[k-1], WIDTH + 3);

    // Random traffic with random backpressure.
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ((req_valid & (N_REQ'(1) << i)) == '0 && $urandom_range(0, 3) == 0) begin
          sa = WIDTH'($urandom);
          sb = ($urandom_range(0, 3) == 0) ? sa : WIDTH'($urandom);
          set_req(i, sa, sb);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    res_ready = 1'b1;
    wait_idle();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_compare_scheduler.md
# serial_compare_scheduler

Shares one MSB-first serial comparator between N_REQ requesters. Each requester presents two parallel WIDTH-bit operands over a valid/ready handshake. A round-robin arbiter grants one requester at a time. The block clears the comparator, shifts both operands into it MSB first, captures the three-way result, and returns it tagged with the requester index over a result valid/ready handshake.

## Interface

Parameters:
- N_REQ, 4, number of requesters (≥1)
- WIDTH, 8, operand width in bits (≥1)
- IDW, $clog2(N_REQ) (min 1), width of requester index

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; at most one bit high
- req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- res_valid  out  1  result available
- res_ready  in  1  result consumer accept
- res_id  out  IDW  index of requester that owns the result
- res_less / res_eq / res_greater  out  1 each  captured comparison result
- busy  out  1  high in any state other than IDLE
- cmp_clr  out  1  synchronous active-high clear to the comparator
- cmp_a / cmp_b  out  1 each  serial operand bits, MSB first
- cmp_less / cmp_eq / cmp_greater  in  1 each  comparator outputs, combinational on current bit and comparator state

## Operation

- FSM states: IDLE, CLEAR, SHIFT, RESULT.
- **IDLE**
  - Grant goes to the first requester with req_valid high, searching from rr_ptr upward and wrapping modulo N_REQ.
  - req_ready[grant] = 1 only in IDLE.
  - On handshake, the block latches req_a/req_b of the granted requester into shift registers a_sh/b_sh, latches the index into res_id, sets rr_ptr = (grant+1) mod N_REQ, and moves to CLEAR.
- **CLEAR**
  - cmp_clr = 1 for exactly one cycle.
  - bit counter = WIDTH-1.
  - Next state is SHIFT.
- **SHIFT**
  - cmp_a = a_sh[WIDTH-1] and cmp_b = b_sh[WIDTH-1]; both shift registers shift left each cycle.
  - The counter decrements each cycle.
  - When the counter is 0, the block captures cmp_less/cmp_eq/cmp_greater into res_less/res_eq/res_greater in that same cycle and moves to RESULT.
  - SHIFT always lasts exactly WIDTH cycles. There is no early termination.
- **RESULT**
  - res_valid = 1, and res_id plus the result bits are held stable.
  - On res_ready, the block moves to IDLE.
  - No request is accepted in RESULT.
- Outside SHIFT, cmp_a = cmp_b = 0. cmp_clr = 0 outside CLEAR.
- Request data is sampled only on handshake; later changes to req_a/req_b are ignored.
- Requesters must hold req_valid and their data until accepted. Dropping req_valid before acceptance is legal and simply removes that requester from arbitration.
- res_less/res_eq/res_greater are forwarded from the comparator unmodified. A correct comparator yields a one-hot result.
- With N_REQ=1, rr_ptr stays 0 and res_id is always 0.

## Timing

- **Reset** (rst low, asynchronous):
  - state goes to IDLE and rr_ptr to 0;
  - res_valid, res_id, res_less, res_eq, res_greater, busy, cmp_clr, cmp_a, cmp_b are all 0;
  - req_ready is combinational from IDLE, so it follows req_valid even during reset.
- **Reset mid-operation:** any in-flight comparison is discarded with no result returned. The first request after release is arbitrated from index 0.
- **Latency:** request handshake in cycle T, then CLEAR in T+1, SHIFT in T+2 to T+1+WIDTH, and res_valid first high in T+2+WIDTH.
- **Throughput:** with res_ready held high, one comparison per WIDTH+3 cycles. The next req_ready is asserted in the cycle after the res handshake.
- **Simultaneous requests:** exactly one grant per IDLE cycle. A requester that keeps req_valid high waits at most N_REQ-1 other grants.
- **Backpressure:** RESULT persists indefinitely while res_ready=0, with outputs unchanged and busy=1.
- **WIDTH=1:** SHIFT lasts one cycle, and the result is captured in that same cycle.

## Test plan

- **Single greater** (N_REQ=4, WIDTH=8): req 0 sends a=0x64, b=0x62, res_ready=1.
  - Expect cmp_clr high at T+1, cmp_a serial 0,1,1,0,0,1,0,0 over T+2..T+9.
  - Expect res_valid at T+10 with id=0, less/eq/greater = 0/0/1.
- **Equal and less:**
  - req 2 sends 0xA5 vs 0xA5: expect id=2, 0/1/0.
  - req 1 sends 0x0F vs 0xF0: expect id=1, 1/0/0.
- **Contention:** all four req_valid held high with distinct operands.
  - Expect grant order 0,1,2,3,0 and matching res_id sequence.
  - Expect successive res_valid rises spaced 11 cycles apart.
- **Wrap priority:** after serving req 3, raise req 1 and req 0 together.
  - Expect req 0 granted first, because rr_ptr wrapped to 0.
- **Backpressure:** hold res_ready=0 for 5 cycles in RESULT.
  - Expect res_valid and result fields held stable, busy=1, all req_ready=0, and return to IDLE one cycle after res_ready=1.
- **Reset mid-SHIFT:** assert rst low at T+5.
  - Expect all outputs 0 immediately and no result delivered.
  - After release, a request of 0x01 vs 0x80 from req 3 returns id=3, 1/0/0 at T'+10.
